uart_rx_fifo: RTL and testbench

Receive-side byte FIFO that sits directly downstream of the UART receiver. It drains the receiver's single-byte holding buffer through a valid/ready handshake and buffers DEPTH bytes for the host. It presents show-ahead read data, a fill-level threshold interrupt, and an idle character-timeout interrupt. It also keeps sticky overrun and underflow status.

---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: show-ahead read port,
// fill-threshold and idle-timeout interrupts, sticky overrun/underflow status.
module uart_rx_fifo #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 640,
    localparam int unsigned CNT_W         = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             host_ready,
    input  logic             overrun_in,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_empty,
    output logic             full,
    output logic [CNT_W-1:0] fifo_count,
    input  logic [CNT_W-1:0] thresh,
    output logic             thresh_irq,
    output logic             timeout_irq,
    input  logic             flush,
    input  logic             clear_status,
    output logic             overrun_sticky,
    output logic             underflow_sticky
);
    localparam int unsigned        AW      = $clog2(DEPTH);
    localparam int unsigned        TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]      TMAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   FULL_CT = CNT_W'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [TW-1:0]    r_timer;
    logic             r_ovr;
    logic             r_udf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CT);
    assign w_empty = (r_count == '0);

    // flush blocks both transfers so the cleared state is not disturbed that cycle
    assign host_ready = ~w_full & ~flush;
    assign w_push     = rx_data_valid & host_ready;
    assign w_pop      = rd_en & ~w_empty & ~flush;

    assign rd_data          = r_mem[r_rd_ptr];
    assign rd_empty         = w_empty;
    assign full             = w_full;
    assign fifo_count       = r_count;
    assign thresh_irq       = (thresh != '0) && (r_count >= thresh);
    assign timeout_irq      = (r_timer == TMAX);
    assign overrun_sticky   = r_ovr;
    assign underflow_sticky = r_udf;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_timer  <= '0;
            r_ovr    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (overrun_in) begin
                r_ovr <= 1'b1;
            end else if (clear_status) begin
                r_ovr <= 1'b0;
            end

            if (rd_en && w_empty && !flush) begin
                r_udf <= 1'b1;
            end else if (clear_status) begin
                r_udf <= 1'b0;
            end

            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_timer  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end

                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase

                // idle timer only runs while data sits untouched in the FIFO
                if (w_push || w_pop || w_empty) begin
                    r_timer <= '0;
                end else if (r_timer != TMAX) begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int TO    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_data_valid;
    logic          host_ready;
    logic          overrun_in;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_empty;
    logic          full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] thresh;
    logic          thresh_irq;
    logic          timeout_irq;
    logic          flush;
    logic          clear_status;
    logic          overrun_sticky;
    logic          underflow_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q[$];
    int         m_timer;
    bit         m_ovr;
    bit         m_udf;

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .host_ready(host_ready), .overrun_in(overrun_in), .rd_en(rd_en),
        .rd_data(rd_data), .rd_empty(rd_empty), .full(full), .fifo_count(fifo_count),
        .thresh(thresh), .thresh_irq(thresh_irq), .timeout_irq(timeout_irq),
        .flush(flush), .clear_status(clear_status), .overrun_sticky(overrun_sticky),
        .underflow_sticky(underflow_sticky)
    );

    always #5 clk = ~clk;

    // Advance the reference model by one clock using the current inputs, then clock the DUT.
    task automatic step();
        int  sz;
        bit  push, pop;
        sz   = m_q.size();
        push = rx_data_valid && (sz < DEPTH) && !flush;
        pop  = rd_en && (sz > 0) && !flush;
        if (!rst_n) begin
            m_q.delete();
            m_timer = 0;
            m_ovr   = 0;
            m_udf   = 0;
        end else begin
            if (overrun_in) m_ovr = 1; else if (clear_status) m_ovr = 0;
            if (rd_en && sz == 0 && !flush) m_udf = 1; else if (clear_status) m_udf = 0;
            if (flush) begin
                m_q.delete();
                m_timer = 0;
            end else begin
                if (push || pop || sz == 0) m_timer = 0;
                else if (m_timer < TO) m_timer++;
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(rx_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_data_valid = 0; rd_en = 0; flush = 0; overrun_in = 0; clear_status = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); thresh = '0; rx_data = '0;
        step(); step();
        rst_n = 1;
        n_tests++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", rd_empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_tests++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", host_ready); end
        n_tests++; if ({thresh_irq, timeout_irq, overrun_sticky, underflow_sticky} !== 4'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {thresh_irq, timeout_irq, overrun_sticky, underflow_sticky}); end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'h3C;
        rx_data_valid = 1;
        for (int i = 0; i < 3; i++) begin
            rx_data = bytes[i];
            step();
            n_tests++; if (fifo_count !== CW'(i + 1)) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", fifo_count, i + 1); end
        end
        rx_data_valid = 0;
        rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (rd_data !== bytes[i]) begin n_fail++; $display("FAIL basic_data: got %0h expected %0h", rd_data, bytes[i]); end
            step();
        end
        rd_en = 0;
        n_tests++; if (rd_empty !== 1'b1 || fifo_count !== '0) begin n_fail++; $display("FAIL basic_drain: got empty=%0b count=%0d expected empty=1 count=0", rd_empty, fifo_count); end
    endtask

    task automatic test_full(input logic [7:0] base);
        rx_data_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = base + 8'(i);
            step();
        end
        n_tests++; if (full !== 1'b1 || host_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags: got full=%0b ready=%0b expected full=1 ready=0", full, host_ready); end
        rx_data = base + 8'h10;
        step();
        n_tests++; if (fifo_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_holdoff: got %0d expected %0d", fifo_count, DEPTH); end
        n_tests++; if (rd_data !== base) begin n_fail++; $display("FAIL full_head: got %0h expected %0h", rd_data, base); end
        rd_en = 1;
        step();
        rd_en = 0;
        n_tests++; if (host_ready !== 1'b1 || fifo_count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL full_pop: got ready=%0b count=%0d expected ready=1 count=%0d", host_ready, fifo_count, DEPTH - 1); end
        step();
        rx_data_valid = 0;
        n_tests++; if (fifo_count !== CW'(DEPTH) || full !== 1'b1) begin n_fail++; $display("FAIL full_refill: got count=%0d expected %0d", fifo_count, DEPTH); end
        rd_en = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_tests++; if (rd_data !== base + 8'(i)) begin n_fail++; $display("FAIL full_order: got %0h expected %0h", rd_data, base + 8'(i)); end
            step();
        end
        rd_en = 0;
        n_tests++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL full_drain: got %0b expected 1", rd_empty); end
    endtask

    task automatic test_simul();
        rx_data_valid = 1;
        for (int i = 0; i < 5; i++) begin rx_data = 8'($urandom); step(); end
        rd_en = 1;
        for (int i = 0; i < 6; i++) begin
            rx_data = 8'($urandom);
            n_tests++; if (rd_data !== m_q[0]) begin n_fail++; $display("FAIL simul_data: got %0h expected %0h", rd_data, m_q[0]); end
            step();
            n_tests++; if (fifo_count !== CW'(5)) begin n_fail++; $display("FAIL simul_count: got %0d expected 5", fifo_count); end
        end
        rx_data_valid = 0;
        while (m_q.size() > 0) begin
            n_tests++; if (rd_data !== m_q[0]) begin n_fail++; $display("FAIL simul_drain: got %0h expected %0h", rd_data, m_q[0]); end
            step();
        end
        n_tests++; if (underflow_sticky !== 1'b0) begin n_fail++; $display("FAIL udf_early: got %0b expected 0", underflow_sticky); end
        step();
        rd_en = 0;
        n_tests++; if (underflow_sticky !== 1'b1 || fifo_count !== '0) begin n_fail++; $display("FAIL udf_set: got udf=%0b count=%0d expected udf=1 count=0", underflow_sticky, fifo_count); end
        clear_status = 1; step(); clear_status = 0;
        n_tests++; if (underflow_sticky !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %0b expected 0", underflow_sticky); end
    endtask

    task automatic test_thresh();
        thresh = CW'(4);
        rx_data_valid = 1;
        for (int i = 0; i < 3; i++) begin rx_data = 8'(i); step(); end
        n_tests++; if (thresh_irq !== 1'b0) begin n_fail++; $display("FAIL thr_below: got %0b expected 0", thresh_irq); end
        step();
        rx_data_valid = 0;
        n_tests++; if (thresh_irq !== 1'b1) begin n_fail++; $display("FAIL thr_at: got %0b expected 1", thresh_irq); end
        rd_en = 1; step(); rd_en = 0;
        n_tests++; if (thresh_irq !== 1'b0) begin n_fail++; $display("FAIL thr_drop: got %0b expected 0", thresh_irq); end
        thresh = '0;
        rx_data_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin rx_data = 8'(i); step(); end
        rx_data_valid = 0;
        n_tests++; if (thresh_irq !== 1'b0 || full !== 1'b1) begin n_fail++; $display("FAIL thr_disabled: got irq=%0b full=%0b expected irq=0 full=1", thresh_irq, full); end
        flush = 1; step(); flush = 0;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 12; i++) step();
        n_tests++; if (timeout_irq !== 1'b0) begin n_fail++; $display("FAIL to_empty: got %0b expected 0", timeout_irq); end
        rx_data = 8'h77; rx_data_valid = 1; step(); rx_data_valid = 0;
        for (int k = 1; k <= TO + 3; k++) begin
            step();
            n_tests++; if (timeout_irq !== (k >= TO)) begin n_fail++; $display("FAIL to_rise: got %0b expected %0b at idle cycle %0d", timeout_irq, k >= TO, k); end
        end
        rd_en = 1; step(); rd_en = 0;
        n_tests++; if (timeout_irq !== 1'b0 || rd_empty !== 1'b1) begin n_fail++; $display("FAIL to_fall: got irq=%0b empty=%0b expected irq=0 empty=1", timeout_irq, rd_empty); end
        for (int i = 0; i < TO + 4; i++) step();
        n_tests++; if (timeout_irq !== 1'b0) begin n_fail++; $display("FAIL to_empty2: got %0b expected 0", timeout_irq); end
    endtask

    task automatic test_status();
        overrun_in = 1; step(); overrun_in = 0;
        n_tests++; if (overrun_sticky !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %0b expected 1", overrun_sticky); end
        overrun_in = 1; clear_status = 1; step(); overrun_in = 0;
        n_tests++; if (overrun_sticky !== 1'b1) begin n_fail++; $display("FAIL ovr_setwins: got %0b expected 1", overrun_sticky); end
        step(); clear_status = 0;
        n_tests++; if (overrun_sticky !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %0b expected 0", overrun_sticky); end
        overrun_in = 1; rd_en = 1; step(); overrun_in = 0; rd_en = 0;
        rx_data_valid = 1;
        for (int i = 0; i < 7; i++) begin rx_data = 8'(i); step(); end
        rx_data_valid = 0;
        n_tests++; if (fifo_count !== CW'(7)) begin n_fail++; $display("FAIL flush_pre: got %0d expected 7", fifo_count); end
        flush = 1; rx_data_valid = 1; rd_en = 1; step(); flush = 0; rx_data_valid = 0; rd_en = 0;
        n_tests++; if (fifo_count !== '0 || rd_empty !== 1'b1) begin n_fail++; $display("FAIL flush: got count=%0d empty=%0b expected count=0 empty=1", fifo_count, rd_empty); end
        n_tests++; if (overrun_sticky !== 1'b1 || underflow_sticky !== 1'b1) begin n_fail++; $display("FAIL flush_sticky: got ovr=%0b udf=%0b expected 1 1", overrun_sticky, underflow_sticky); end
        rx_data_valid = 1;
        for (int i = 0; i < 5; i++) begin rx_data = 8'($urandom); step(); end
        rst_n = 0; step(); rst_n = 1; rx_data_valid = 0;
        n_tests++; if (fifo_count !== '0 || rd_empty !== 1'b1 || full !== 1'b0 || host_ready !== 1'b1)
            begin n_fail++; $display("FAIL rst_mid: got count=%0d empty=%0b full=%0b ready=%0b expected 0 1 0 1", fifo_count, rd_empty, full, host_ready); end
        n_tests++; if ({timeout_irq, overrun_sticky, underflow_sticky} !== 3'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", {timeout_irq, overrun_sticky, underflow_sticky}); end
    endtask

    task automatic test_random();
        int sz;
        for (int c = 0; c < 800; c++) begin
            rx_data       = 8'($urandom);
            rx_data_valid = ($urandom_range(0, 99) < 45);
            rd_en         = ($urandom_range(0, 99) < (c % 200 < 100 ? 25 : 60));
            if ($urandom_range(0, 9) == 0) begin rx_data_valid = 0; rd_en = 0; end
            flush         = ($urandom_range(0, 63) == 0);
            overrun_in    = ($urandom_range(0, 31) == 0);
            clear_status  = ($urandom_range(0, 15) == 0);
            rst_n         = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 31) == 0) thresh = CW'($urandom_range(0, DEPTH));
            step();
            sz = m_q.size();
            n_tests++; if (fifo_count !== CW'(sz)) begin n_fail++; $display("FAIL rnd_count: cyc %0d got %0d expected %0d", c, fifo_count, sz); end
            n_tests++; if (rd_empty !== (sz == 0) || full !== (sz == DEPTH))
                begin n_fail++; $display("FAIL rnd_flags: cyc %0d got empty=%0b full=%0b expected size %0d", c, rd_empty, full, sz); end
            n_tests++; if (host_ready !== (sz < DEPTH && !flush)) begin n_fail++; $display("FAIL rnd_ready: cyc %0d got %0b", c, host_ready); end
            if (sz > 0) begin
                n_tests++; if (rd_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_data: cyc %0d got %0h expected %0h", c, rd_data, m_q[0]); end
            end
            n_tests++; if (thresh_irq !== (thresh != 0 && sz >= int'(thresh))) begin n_fail++; $display("FAIL rnd_thr: cyc %0d got %0b", c, thresh_irq); end
            n_tests++; if (timeout_irq !== (m_timer == TO)) begin n_fail++; $display("FAIL rnd_to: cyc %0d got %0b expected %0b", c, timeout_irq, m_timer == TO); end
            n_tests++; if (overrun_sticky !== m_ovr || underflow_sticky !== m_udf)
                begin n_fail++; $display("FAIL rnd_sticky: cyc %0d got %0b%0b expected %0b%0b", c, overrun_sticky, underflow_sticky, m_ovr, m_udf); end
        end
        idle_inputs(); rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full(8'h00);
        test_full(8'h40);
        test_simul();
        test_thresh();
        test_timeout();
        test_status();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
